// File: rtl/ip_reg_bridge_pkg.sv
// Shared constants and types for the register/IP bridge.
// Optional write counter enabled by defining IP_REG_BRIDGE_WCNT_EN.
package ip_reg_bridge_pkg;

    localparam int unsigned WCNT_W     = 16;
    localparam int unsigned NUM_CH_DEF = 3;
    localparam int unsigned DW_DEF     = 32;

    typedef enum logic [0:0] {
        Empty = 1'b0,
        Full  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ip_reg_bridge_ch.sv
// One bridge channel: registered write path plus a one-entry read holding buffer.
// Defining IP_REG_BRIDGE_WCNT_EN adds a wrapping 16-bit write counter.
module ip_reg_bridge_ch
    import ip_reg_bridge_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              wr_en_i,
    output logic              ack_o,
    output logic [DW-1:0]     wdata_o,
    output logic              wupd_o,
    input  logic [DW-1:0]     rdata_i,
    input  logic              rvalid_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              ovf_o,
`ifdef IP_REG_BRIDGE_WCNT_EN
    output logic [WCNT_W-1:0] wcnt_o,
`endif
    input  logic              ovf_clr_i
);

    logic [DW-1:0] wdata_q, wdata_d;
    logic          wupd_q, wupd_d;
    rd_state_e     state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ovf_q, ovf_d;
    logic          ovf_set;

    always_comb begin
        wdata_d = wdata_q;
        wupd_d  = wr_en_i;
        if (wr_en_i) begin
            wdata_d = wr_data_i;
        end

        state_d = state_q;
        rdata_d = rdata_q;
        ovf_set = 1'b0;
        unique case (state_q)
            Empty: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    state_d = Full;
                end
            end
            Full: begin
                // A consumed slot may be refilled in the same cycle without overrun.
                if (rvalid_i && rd_ready_i) begin
                    rdata_d = rdata_i;
                end else if (rd_ready_i) begin
                    state_d = Empty;
                end else if (rvalid_i) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = Empty;
        endcase

        // Set wins over clear so a coincident overrun is never lost.
        ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdata_q <= '0;
            wupd_q  <= 1'b0;
            state_q <= Empty;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wdata_q <= wdata_d;
            wupd_q  <= wupd_d;
            state_q <= state_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wdata_o    = wdata_q;
    assign wupd_o     = wupd_q;
    assign ack_o      = wupd_q;
    assign rd_data_o  = rdata_q;
    assign rd_valid_o = (state_q == Full);
    assign ovf_o      = ovf_q;

`ifdef IP_REG_BRIDGE_WCNT_EN
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (wr_en_i) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wcnt_o = wcnt_q;
`endif

endmodule

// File: rtl/ip_reg_bridge.sv
// Multi-channel register/IP bridge; channels are independent instances of ip_reg_bridge_ch.
// Defining IP_REG_BRIDGE_WCNT_EN adds the per-channel wcnt_o write counters.
module ip_reg_bridge
    import ip_reg_bridge_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH*DW-1:0]     reg2ip_data_i,
    input  logic [NUM_CH-1:0]        reg2ip_en_i,
    output logic [NUM_CH-1:0]        reg2ip_ack_o,
    output logic [NUM_CH*DW-1:0]     hw_wdata_o,
    output logic [NUM_CH-1:0]        hw_wupd_o,
    input  logic [NUM_CH*DW-1:0]     hw_rdata_i,
    input  logic [NUM_CH-1:0]        hw_rvalid_i,
    output logic [NUM_CH*DW-1:0]     ip2reg_data_o,
    output logic [NUM_CH-1:0]        ip2reg_valid_o,
    input  logic [NUM_CH-1:0]        ip2reg_ready_i,
    output logic [NUM_CH-1:0]        ip2reg_ovf_o,
`ifdef IP_REG_BRIDGE_WCNT_EN
    output logic [NUM_CH*WCNT_W-1:0] wcnt_o,
`endif
    input  logic [NUM_CH-1:0]        ovf_clr_i
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ip_reg_bridge_ch #(
            .DW (DW)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wr_data_i  (reg2ip_data_i[c*DW +: DW]),
            .wr_en_i    (reg2ip_en_i[c]),
            .ack_o      (reg2ip_ack_o[c]),
            .wdata_o    (hw_wdata_o[c*DW +: DW]),
            .wupd_o     (hw_wupd_o[c]),
            .rdata_i    (hw_rdata_i[c*DW +: DW]),
            .rvalid_i   (hw_rvalid_i[c]),
            .rd_data_o  (ip2reg_data_o[c*DW +: DW]),
            .rd_valid_o (ip2reg_valid_o[c]),
            .rd_ready_i (ip2reg_ready_i[c]),
            .ovf_o      (ip2reg_ovf_o[c]),
`ifdef IP_REG_BRIDGE_WCNT_EN
            .wcnt_o     (wcnt_o[c*WCNT_W +: WCNT_W]),
`endif
            .ovf_clr_i  (ovf_clr_i[c])
        );
    end

endmodule

// File: tb/tb_ip_reg_bridge.sv
// Directed self-checking bench for ip_reg_bridge (3 channels x 32 bits).
// The counter test runs only when IP_REG_BRIDGE_WCNT_EN is defined.
module tb_ip_reg_bridge;

    localparam int unsigned NC = 3;
    localparam int unsigned W  = 32;

    logic            clk_i;
    logic            rst_ni;
    logic [NC*W-1:0] reg2ip_data_i;
    logic [NC-1:0]   reg2ip_en_i;
    logic [NC-1:0]   reg2ip_ack_o;
    logic [NC*W-1:0] hw_wdata_o;
    logic [NC-1:0]   hw_wupd_o;
    logic [NC*W-1:0] hw_rdata_i;
    logic [NC-1:0]   hw_rvalid_i;
    logic [NC*W-1:0] ip2reg_data_o;
    logic [NC-1:0]   ip2reg_valid_o;
    logic [NC-1:0]   ip2reg_ready_i;
    logic [NC-1:0]   ip2reg_ovf_o;
    logic [NC-1:0]   ovf_clr_i;
`ifdef IP_REG_BRIDGE_WCNT_EN
    logic [NC*16-1:0] wcnt_o;
`endif

    int checks = 0;
    int errors = 0;

    ip_reg_bridge #(
        .NUM_CH (NC),
        .DW     (W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .reg2ip_data_i  (reg2ip_data_i),
        .reg2ip_en_i    (reg2ip_en_i),
        .reg2ip_ack_o   (reg2ip_ack_o),
        .hw_wdata_o     (hw_wdata_o),
        .hw_wupd_o      (hw_wupd_o),
        .hw_rdata_i     (hw_rdata_i),
        .hw_rvalid_i    (hw_rvalid_i),
        .ip2reg_data_o  (ip2reg_data_o),
        .ip2reg_valid_o (ip2reg_valid_o),
        .ip2reg_ready_i (ip2reg_ready_i),
        .ip2reg_ovf_o   (ip2reg_ovf_o),
`ifdef IP_REG_BRIDGE_WCNT_EN
        .wcnt_o         (wcnt_o),
`endif
        .ovf_clr_i      (ovf_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wdata"}, 128'(hw_wdata_o), 128'd0);
        check({tag, " wupd"}, 128'(hw_wupd_o), 128'd0);
        check({tag, " ack"}, 128'(reg2ip_ack_o), 128'd0);
        check({tag, " rdata"}, 128'(ip2reg_data_o), 128'd0);
        check({tag, " valid"}, 128'(ip2reg_valid_o), 128'd0);
        check({tag, " ovf"}, 128'(ip2reg_ovf_o), 128'd0);
`ifdef IP_REG_BRIDGE_WCNT_EN
        check({tag, " wcnt"}, 128'(wcnt_o), 128'd0);
`endif
    endtask

    initial begin
        rst_ni         = 1'b0;
        reg2ip_data_i  = '0;
        reg2ip_en_i    = '0;
        hw_rdata_i     = '0;
        hw_rvalid_i    = '0;
        ip2reg_ready_i = '0;
        ovf_clr_i      = '0;
        #1;
        check_all_zero("reset");
        step();
        step();
        rst_ni = 1'b1;

        // Single write on channel 1; neighbours carry junk data but no strobe.
        reg2ip_data_i = {32'hFFFF_FFFF, 32'h0000_2468, 32'hFFFF_FFFF};
        reg2ip_en_i   = 3'b010;
        step();
        reg2ip_en_i   = 3'b000;
        check("wr1 wdata", 128'(hw_wdata_o), 128'({32'h0, 32'h2468, 32'h0}));
        check("wr1 ack", 128'(reg2ip_ack_o), 128'(3'b010));
        check("wr1 wupd", 128'(hw_wupd_o), 128'(3'b010));
        step();
        check("wr1 ack drop", 128'(reg2ip_ack_o), 128'd0);
        check("wr1 wupd drop", 128'(hw_wupd_o), 128'd0);
        check("wr1 hold", 128'(hw_wdata_o), 128'({32'h0, 32'h2468, 32'h0}));

        // Back-to-back writes on channel 0.
        reg2ip_data_i = {32'h0, 32'h0, 32'h11};
        reg2ip_en_i   = 3'b001;
        step();
        reg2ip_data_i = {32'h0, 32'h0, 32'h22};
        check("b2b first ack", 128'(reg2ip_ack_o), 128'(3'b001));
        check("b2b first data", 128'(hw_wdata_o), 128'({32'h0, 32'h2468, 32'h11}));
        step();
        reg2ip_en_i = 3'b000;
        check("b2b second ack", 128'(reg2ip_ack_o), 128'(3'b001));
        check("b2b second data", 128'(hw_wdata_o), 128'({32'h0, 32'h2468, 32'h22}));
        step();
        check("b2b ack drop", 128'(reg2ip_ack_o), 128'd0);

        // Read on channel 0, held until ready.
        hw_rdata_i  = {32'h0, 32'h0, 32'h369C};
        hw_rvalid_i = 3'b001;
        step();
        hw_rvalid_i = 3'b000;
        check("rd valid", 128'(ip2reg_valid_o), 128'(3'b001));
        check("rd data", 128'(ip2reg_data_o), 128'({32'h0, 32'h0, 32'h369C}));
        step();
        check("rd held valid", 128'(ip2reg_valid_o), 128'(3'b001));
        ip2reg_ready_i = 3'b001;
        step();
        check("rd consumed", 128'(ip2reg_valid_o), 128'd0);
        check("rd data kept", 128'(ip2reg_data_o), 128'({32'h0, 32'h0, 32'h369C}));
        step();
        check("ready while empty", 128'(ip2reg_valid_o), 128'd0);
        ip2reg_ready_i = 3'b000;

        // Overrun: full buffer must not be overwritten.
        hw_rdata_i  = {32'h0, 32'h0, 32'h48D0};
        hw_rvalid_i = 3'b001;
        step();
        hw_rdata_i  = {32'h0, 32'h0, 32'h1111};
        step();
        hw_rvalid_i = 3'b000;
        check("ovf data kept", 128'(ip2reg_data_o), 128'({32'h0, 32'h0, 32'h48D0}));
        check("ovf flag", 128'(ip2reg_ovf_o), 128'(3'b001));
        check("ovf valid", 128'(ip2reg_valid_o), 128'(3'b001));
        step();
        check("ovf sticky", 128'(ip2reg_ovf_o), 128'(3'b001));
        ovf_clr_i = 3'b001;
        step();
        ovf_clr_i = 3'b000;
        check("ovf cleared", 128'(ip2reg_ovf_o), 128'd0);

        // Clear coinciding with a new overrun leaves the flag set.
        hw_rdata_i  = {32'h0, 32'h0, 32'h2222};
        hw_rvalid_i = 3'b001;
        ovf_clr_i   = 3'b001;
        step();
        hw_rvalid_i = 3'b000;
        check("clr+ovf flag", 128'(ip2reg_ovf_o), 128'(3'b001));
        step();
        ovf_clr_i = 3'b000;
        check("ovf clear again", 128'(ip2reg_ovf_o), 128'd0);
        check("data still 48D0", 128'(ip2reg_data_o), 128'({32'h0, 32'h0, 32'h48D0}));

        // Simultaneous consume and refill.
        hw_rdata_i     = {32'h0, 32'h0, 32'hAAAA};
        hw_rvalid_i    = 3'b001;
        ip2reg_ready_i = 3'b001;
        step();
        hw_rvalid_i    = 3'b000;
        ip2reg_ready_i = 3'b000;
        check("simul data", 128'(ip2reg_data_o), 128'({32'h0, 32'h0, 32'hAAAA}));
        check("simul valid", 128'(ip2reg_valid_o), 128'(3'b001));
        check("simul ovf", 128'(ip2reg_ovf_o), 128'd0);

        // Reset mid-operation with an ack pulse in flight.
        reg2ip_data_i = {32'h0000_7777, 32'h0, 32'h0};
        reg2ip_en_i   = 3'b100;
        step();
        reg2ip_en_i   = 3'b000;
        check("pre-rst ack", 128'(reg2ip_ack_o), 128'(3'b100));
        #1;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async rst");
        step();
        rst_ni = 1'b1;

        // First cycle after release samples inputs.
        reg2ip_data_i = {32'h0, 32'h55, 32'h0};
        reg2ip_en_i   = 3'b010;
        step();
        reg2ip_en_i   = 3'b000;
        check("post-rst wdata", 128'(hw_wdata_o), 128'({32'h0, 32'h55, 32'h0}));
        check("post-rst ack", 128'(reg2ip_ack_o), 128'(3'b010));

`ifdef IP_REG_BRIDGE_WCNT_EN
        reg2ip_data_i = {32'h1, 32'h0, 32'h0};
        reg2ip_en_i   = 3'b100;
        repeat (65537) step();
        reg2ip_en_i   = 3'b000;
        check("wcnt wrap", 128'(wcnt_o), 128'({16'd1, 16'd1, 16'd0}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_reg_bridge.md
IP_REG_BRIDGE -- requirements
Module: ip_reg_bridge

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent channels, legal range 1..16.
REQ-002 Parameter DW, default 32: data width per channel, legal range 8..64.
REQ-003 Port clk_i  in  1: single clock; all logic rising-edge.
REQ-004 Port rst_ni  in  1: asynchronous active-low reset.
REQ-005 Port reg2ip_data_i  in  NUM_CH*DW: register-side write data; channel c at [c*DW +: DW].
REQ-006 Port reg2ip_en_i  in  NUM_CH: per-channel write strobe.
REQ-007 Port reg2ip_ack_o  out  NUM_CH: per-channel write acknowledge pulse.
REQ-008 Port hw_wdata_o  out  NUM_CH*DW: stored write value driven to hardware.
REQ-009 Port hw_wupd_o  out  NUM_CH: one-cycle hardware update pulse.
REQ-010 Port hw_rdata_i  in  NUM_CH*DW: hardware status data.
REQ-011 Port hw_rvalid_i  in  NUM_CH: hardware status strobe.
REQ-012 Port ip2reg_data_o  out  NUM_CH*DW: held read data toward register file.
REQ-013 Port ip2reg_valid_o  out  NUM_CH: read data valid.
REQ-014 Port ip2reg_ready_i  in  NUM_CH: register file consumes read data.
REQ-015 Port ip2reg_ovf_o  out  NUM_CH: sticky read-overrun flag.
REQ-016 Port ovf_clr_i  in  NUM_CH: overrun clear strobe.
REQ-017 Port wcnt_o  out  NUM_CH*16: per-channel write count (present only with REQ-032 macro).

Function
REQ-018 Channels SHALL be fully independent; no cross-channel ordering or arbitration.
REQ-019 reg2ip_en_i[c]=1 in cycle N SHALL load hw_wdata_o[c] and assert hw_wupd_o[c] and reg2ip_ack_o[c] for exactly cycle N+1 (registered, latency 1).
REQ-020 Strobes in consecutive cycles SHALL each produce an ack/update pulse; hw_wdata_o tracks the latest write.
REQ-021 Read path per channel is a 2-state machine: EMPTY (valid=0), FULL (valid=1).
REQ-022 EMPTY + hw_rvalid_i -> capture hw_rdata_i, FULL next cycle (latency 1).
REQ-023 FULL + ip2reg_ready_i, no hw_rvalid_i -> EMPTY next cycle; data output holds last value.
REQ-024 FULL + ip2reg_ready_i + hw_rvalid_i same cycle -> capture new data, stay FULL, no overrun.
REQ-025 FULL + hw_rvalid_i without ready -> keep old data (no overwrite), set ip2reg_ovf_o[c] next cycle.
REQ-026 ip2reg_ready_i while EMPTY SHALL be ignored.
REQ-027 ip2reg_ovf_o SHALL stay set until ovf_clr_i; clear and new overrun in same cycle -> flag remains set.

Reset
REQ-028 Reset assertion SHALL asynchronously force: hw_wdata_o=0, hw_wupd_o=0, reg2ip_ack_o=0, ip2reg_data_o=0, ip2reg_valid_o=0 (EMPTY), ip2reg_ovf_o=0, wcnt_o=0.
REQ-029 Reset mid-handshake SHALL discard pending read data and suppress any in-flight ack/update pulse.
REQ-030 First cycle after deassertion SHALL sample inputs normally.

Configuration
REQ-031 Macro IP_REG_BRIDGE_WCNT_EN SHALL compile in a 16-bit per-channel write counter.
REQ-032 With IP_REG_BRIDGE_WCNT_EN defined: counter increments once per accepted reg2ip_en_i, wraps 0xFFFF->0x0000, drives wcnt_o; without it: counter and wcnt_o port absent.

Structure
REQ-033 Package ip_reg_bridge_pkg SHALL hold WCNT_W=16, default NUM_CH/DW constants, and rd_state_e enum (EMPTY, FULL).
REQ-034 Per-channel logic SHALL live in sub-module ip_reg_bridge_ch, instantiated NUM_CH times by generate loop.

Verification
REQ-035 Write: en[1]=1 with data 0x0000_2468 -> cycle+1 hw_wdata_o[1]=0x2468, ack[1]=wupd[1]=1 one cycle, channels 0/2 unchanged.
REQ-036 Read: rvalid[0] with 0x369C, ready=0 -> valid[0]=1, data 0x369C held; ready=1 -> valid=0 next cycle.
REQ-037 Overrun: FULL holding 0x48D0, rvalid with 0x1111, ready=0 -> data stays 0x48D0, ovf=1; ovf_clr -> ovf=0.
REQ-038 Simultaneous: FULL, ready=1 and rvalid with 0xAAAA same cycle -> data 0xAAAA, valid=1, ovf=0.
REQ-039 Reset mid-operation: channel FULL and ack pending, rst_ni low -> all outputs 0 immediately, not clock-gated.
REQ-040 With IP_REG_BRIDGE_WCNT_EN: 65537 writes to channel 2 -> wcnt_o[2]=1.
